// File: rtl/id_ex_operand_stage_if.sv
// ----------------------------------------------------------------------------
// id_ex_operand_stage_if
//   Bundles every non-clock, non-reset signal of the ID/EX operand stage.
//
//   Decode side : flush, in_valid/in_ready and the decoded instruction fields
//                 (in_alu_sel, in_rs/rt/rd, in_rs_data/rt_data, immediate and
//                 shift controls, in_wr_en, in_is_load).
//   Feedback    : ex_result (ALU result of the instruction held in the stage),
//                 mem_* and wb_* writeback info from the later stages.
//   EX side     : out_valid/out_ready, A, B, ALU_sel, out_rd, out_wr_en,
//                 out_is_load, out_store_data, stall.
//
//   modport slave  : seen by the stage itself.
//   modport master : seen by whatever drives the stage (decode/EX/bench).
// ----------------------------------------------------------------------------
interface id_ex_operand_stage_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
);
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_alu_sel;
    logic [REG_AW-1:0] in_rs;
    logic [REG_AW-1:0] in_rt;
    logic [REG_AW-1:0] in_rd;
    logic [DATA_W-1:0] in_rs_data;
    logic [DATA_W-1:0] in_rt_data;
    logic              in_use_imm;
    logic              in_imm_sign;
    logic [15:0]       in_imm;
    logic              in_shift_imm;
    logic [4:0]        in_shamt;
    logic              in_wr_en;
    logic              in_is_load;

    logic [DATA_W-1:0] ex_result;
    logic              mem_wr_en;
    logic [REG_AW-1:0] mem_rd;
    logic [DATA_W-1:0] mem_result;
    logic              wb_wr_en;
    logic [REG_AW-1:0] wb_rd;
    logic [DATA_W-1:0] wb_result;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] A;
    logic [DATA_W-1:0] B;
    logic [2:0]        ALU_sel;
    logic [REG_AW-1:0] out_rd;
    logic              out_wr_en;
    logic              out_is_load;
    logic [DATA_W-1:0] out_store_data;
    logic              stall;

    modport slave (
        input  flush, in_valid, in_alu_sel, in_rs, in_rt, in_rd,
               in_rs_data, in_rt_data, in_use_imm, in_imm_sign, in_imm,
               in_shift_imm, in_shamt, in_wr_en, in_is_load,
               ex_result, mem_wr_en, mem_rd, mem_result,
               wb_wr_en, wb_rd, wb_result, out_ready,
        output in_ready, out_valid, A, B, ALU_sel, out_rd, out_wr_en,
               out_is_load, out_store_data, stall
    );

    modport master (
        output flush, in_valid, in_alu_sel, in_rs, in_rt, in_rd,
               in_rs_data, in_rt_data, in_use_imm, in_imm_sign, in_imm,
               in_shift_imm, in_shamt, in_wr_en, in_is_load,
               ex_result, mem_wr_en, mem_rd, mem_result,
               wb_wr_en, wb_rd, wb_result, out_ready,
        input  in_ready, out_valid, A, B, ALU_sel, out_rd, out_wr_en,
               out_is_load, out_store_data, stall
    );
endinterface

// File: rtl/id_ex_operand_stage.sv
// ----------------------------------------------------------------------------
// id_ex_operand_stage
//   ID/EX pipeline register directly upstream of the ALU. Registers the decoded
//   instruction, resolves RAW hazards and presents registered A, B and ALU_sel
//   so the ALU can work combinationally in EX. Valid/ready on both sides.
//
//   Ports:
//     clk  - clock
//     rst  - asynchronous active-high reset (all outputs 0, in_ready 0)
//     bus  - id_ex_operand_stage_if.slave (decode, feedback and EX signals)
//
//   Build option:
//     ID_EX_BYPASS_EN defined   : full forwarding network (own stage, EX/MEM,
//                                 MEM/WB); only load-use stalls.
//     ID_EX_BYPASS_EN undefined : no forwarding; operands come straight from
//                                 the register file and the stage stalls while
//                                 any used source has a pending writer.
// ----------------------------------------------------------------------------
module id_ex_operand_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    id_ex_operand_stage_if.slave  bus
);

    // Stage registers
    logic              valid_q;
    logic              wr_en_q;
    logic              is_load_q;
    logic [REG_AW-1:0] rd_q;
    logic [2:0]        sel_q;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic [DATA_W-1:0] store_q;

    // Combinational operand build
    logic              rs_used;
    logic              rt_used;
    logic              hazard;
    logic              load_en;
    logic              accept;
    logic [DATA_W-1:0] rs_val;
    logic [DATA_W-1:0] rt_val;
    logic [DATA_W-1:0] imm_ext;
    logic [DATA_W-1:0] a_next;
    logic [DATA_W-1:0] b_next;

    // Shift-immediate reads only rt; immediate forms (other than shifts) do
    // not read rt as an operand.
    assign rs_used = !bus.in_shift_imm;
    assign rt_used = !bus.in_use_imm || bus.in_shift_imm;

`ifdef ID_EX_BYPASS_EN
    // Highest priority first: own stage (non-load only, its result is on
    // ex_result this cycle), EX/MEM, MEM/WB, register file. r0 is hard zero.
    function automatic logic [DATA_W-1:0] fwd(
        input logic [REG_AW-1:0] r,
        input logic [DATA_W-1:0] rf_data,
        input logic              own_en,
        input logic [REG_AW-1:0] own_rd,
        input logic [DATA_W-1:0] own_data,
        input logic              mem_en,
        input logic [REG_AW-1:0] mem_rd,
        input logic [DATA_W-1:0] mem_data,
        input logic              wb_en,
        input logic [REG_AW-1:0] wb_rd,
        input logic [DATA_W-1:0] wb_data
    );
        if (r == '0)                 return '0;
        if (own_en && own_rd == r)   return own_data;
        if (mem_en && mem_rd == r)   return mem_data;
        if (wb_en  && wb_rd  == r)   return wb_data;
        return rf_data;
    endfunction

    logic own_fwd_en;
    assign own_fwd_en = valid_q && wr_en_q && !is_load_q;

    assign rs_val = fwd(bus.in_rs, bus.in_rs_data, own_fwd_en, rd_q, bus.ex_result,
                        bus.mem_wr_en, bus.mem_rd, bus.mem_result,
                        bus.wb_wr_en, bus.wb_rd, bus.wb_result);
    assign rt_val = fwd(bus.in_rt, bus.in_rt_data, own_fwd_en, rd_q, bus.ex_result,
                        bus.mem_wr_en, bus.mem_rd, bus.mem_result,
                        bus.wb_wr_en, bus.wb_rd, bus.wb_result);

    // Load data is not available until MEM, so a dependent instruction waits
    // one cycle and then picks the value up from the EX/MEM bypass.
    logic load_live;
    assign load_live = valid_q && is_load_q && (rd_q != '0);
    assign hazard    = load_live &&
                       ((rs_used && rd_q == bus.in_rs) || (rt_used && rd_q == bus.in_rt));
`else
    // Without bypassing, a source is unsafe while any downstream stage still
    // has to write it back.
    function automatic logic pending(
        input logic [REG_AW-1:0] r,
        input logic              own_en,
        input logic [REG_AW-1:0] own_rd,
        input logic              mem_en,
        input logic [REG_AW-1:0] mem_rd,
        input logic              wb_en,
        input logic [REG_AW-1:0] wb_rd
    );
        return (r != '0) && ((own_en && own_rd == r) ||
                             (mem_en && mem_rd == r) ||
                             (wb_en  && wb_rd  == r));
    endfunction

    logic own_wr;
    assign own_wr = valid_q && wr_en_q;

    assign rs_val = bus.in_rs_data;
    assign rt_val = bus.in_rt_data;
    assign hazard =
        (rs_used && pending(bus.in_rs, own_wr, rd_q, bus.mem_wr_en, bus.mem_rd,
                            bus.wb_wr_en, bus.wb_rd)) ||
        (rt_used && pending(bus.in_rt, own_wr, rd_q, bus.mem_wr_en, bus.mem_rd,
                            bus.wb_wr_en, bus.wb_rd));
`endif

    assign imm_ext = {{(DATA_W-16){bus.in_imm_sign & bus.in_imm[15]}}, bus.in_imm};

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path leaves it unassigned, which would otherwise infer a latch.
        a_next = rs_val;
        b_next = bus.in_use_imm ? imm_ext : rt_val;
        if (bus.in_shift_imm) begin
            a_next = rt_val;
            b_next = {{(DATA_W-5){1'b0}}, bus.in_shamt};
        end
    end

    // Stage can take a new entry when it is empty or its content leaves now.
    assign load_en = !valid_q || bus.out_ready;
    assign accept  = bus.in_valid && bus.in_ready;

    assign bus.in_ready = !rst && load_en && !hazard && !bus.flush;
    assign bus.stall    = !rst && bus.in_valid && hazard;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the payload registers are reset too, not just valid_q,
            // because A/B/ALU_sel must read 0 while reset is asserted.
            valid_q   <= 1'b0;
            wr_en_q   <= 1'b0;
            is_load_q <= 1'b0;
            rd_q      <= '0;
            sel_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            store_q   <= '0;
        end else if (bus.flush) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values, independent of statement order.
            valid_q <= 1'b0;
        end else if (load_en) begin
            // A hazard here (with the old entry leaving) produces a bubble.
            valid_q <= accept;
            if (accept) begin
                wr_en_q   <= bus.in_wr_en;
                is_load_q <= bus.in_is_load;
                rd_q      <= bus.in_rd;
                sel_q     <= bus.in_alu_sel;
                a_q       <= a_next;
                b_q       <= b_next;
                store_q   <= rt_val;
            end
        end
    end

    assign bus.out_valid      = valid_q;
    assign bus.out_wr_en      = wr_en_q;
    assign bus.out_is_load    = is_load_q;
    assign bus.out_rd         = rd_q;
    assign bus.ALU_sel        = sel_q;
    assign bus.A              = a_q;
    assign bus.B              = b_q;
    assign bus.out_store_data = store_q;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// ----------------------------------------------------------------------------
// tb_id_ex_operand_stage
//   Directed vectors for id_ex_operand_stage. Inputs change on the falling
//   edge; registered outputs are sampled 1 time unit after the rising edge,
//   combinational outputs 1 time unit after the inputs change. Expected values
//   follow the build option ID_EX_BYPASS_EN where behaviour differs.
// ----------------------------------------------------------------------------
module tb_id_ex_operand_stage;

    logic clk;
    logic rst;
    int   n_vec = 0;
    int   n_bad = 0;

    id_ex_operand_stage_if #(.DATA_W(32), .REG_AW(5)) bus ();

    id_ex_operand_stage #(.DATA_W(32), .REG_AW(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        bus.flush        = 1'b0;
        bus.in_valid     = 1'b0;
        bus.in_alu_sel   = '0;
        bus.in_rs        = '0;
        bus.in_rt        = '0;
        bus.in_rd        = '0;
        bus.in_rs_data   = '0;
        bus.in_rt_data   = '0;
        bus.in_use_imm   = 1'b0;
        bus.in_imm_sign  = 1'b0;
        bus.in_imm       = '0;
        bus.in_shift_imm = 1'b0;
        bus.in_shamt     = '0;
        bus.in_wr_en     = 1'b0;
        bus.in_is_load   = 1'b0;
        bus.ex_result    = '0;
        bus.mem_wr_en    = 1'b0;
        bus.mem_rd       = '0;
        bus.mem_result   = '0;
        bus.wb_wr_en     = 1'b0;
        bus.wb_rd        = '0;
        bus.wb_result    = '0;
        bus.out_ready    = 1'b1;
    endtask

    // Register-register instruction writing rd; other fields defaulted.
    task automatic offer(input logic [2:0] sel, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [31:0] rs_d, input logic [31:0] rt_d);
        bus.in_valid     = 1'b1;
        bus.in_alu_sel   = sel;
        bus.in_rs        = rs;
        bus.in_rt        = rt;
        bus.in_rd        = rd;
        bus.in_rs_data   = rs_d;
        bus.in_rt_data   = rt_d;
        bus.in_use_imm   = 1'b0;
        bus.in_imm_sign  = 1'b0;
        bus.in_imm       = '0;
        bus.in_shift_imm = 1'b0;
        bus.in_shamt     = '0;
        bus.in_wr_en     = 1'b1;
        bus.in_is_load   = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        quiet();
        tick();
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_in_ready",  bus.in_ready,  0);
        check("rst_A",         bus.A,         0);
        @(negedge clk);
        rst = 1'b0;

        // ---- immediate extension ----
        offer(3'b000, 5'd1, 5'd0, 5'd2, 32'h11, 32'h0);
        bus.in_use_imm  = 1'b1;
        bus.in_imm_sign = 1'b1;
        bus.in_imm      = 16'hFFFE;
        #1 check("imm_in_ready", bus.in_ready, 1);
        tick();
        check("imm_out_valid", bus.out_valid, 1);
        check("imm_A",         bus.A, 32'h11);
        check("imm_sext_B",    bus.B, 32'hFFFF_FFFE);
        @(negedge clk);
        bus.in_imm_sign = 1'b0;
        tick();
        check("imm_zext_B",    bus.B, 32'h0000_FFFE);

        // ---- shift immediate ----
        @(negedge clk);
        offer(3'b101, 5'd9, 5'd4, 5'd5, 32'h999, 32'h80);
        bus.in_shift_imm = 1'b1;
        bus.in_shamt     = 5'd7;
        tick();
        check("shf_A",     bus.A, 32'h80);
        check("shf_B",     bus.B, 32'h7);
        check("shf_store", bus.out_store_data, 32'h80);
        check("shf_sel",   bus.ALU_sel, 3'b101);
        @(negedge clk);
        quiet();
        tick();
        check("idle_out_valid", bus.out_valid, 0);

        // ---- add r3,r1,r2 ; sub r4,r3,r1 ----
        @(negedge clk);
        offer(3'b000, 5'd1, 5'd2, 5'd3, 32'h5, 32'hB);
        tick();
        check("add_A", bus.A, 32'h5);
        check("add_B", bus.B, 32'hB);
        @(negedge clk);
        offer(3'b001, 5'd3, 5'd1, 5'd4, 32'h0, 32'h5);
        bus.ex_result = 32'h10;
`ifdef ID_EX_BYPASS_EN
        #1 check("sub_stall", bus.stall, 0);
        tick();
        check("sub_valid", bus.out_valid, 1);
        check("sub_A_fwd", bus.A, 32'h10);
        check("sub_B",     bus.B, 32'h5);
        check("sub_rd",    bus.out_rd, 5'd4);
`else
        #1 check("sub_stall_own", bus.stall, 1);
        check("sub_ready_own", bus.in_ready, 0);
        tick();
        check("sub_bubble", bus.out_valid, 0);
        @(negedge clk);
        bus.ex_result = '0;
        bus.mem_wr_en = 1'b1; bus.mem_rd = 5'd3; bus.mem_result = 32'h10;
        #1 check("sub_stall_mem", bus.stall, 1);
        tick();
        @(negedge clk);
        bus.mem_wr_en = 1'b0;
        bus.wb_wr_en = 1'b1; bus.wb_rd = 5'd3; bus.wb_result = 32'h10;
        #1 check("sub_stall_wb", bus.stall, 1);
        tick();
        @(negedge clk);
        bus.wb_wr_en = 1'b0;
        bus.in_rs_data = 32'h10;
        #1 check("sub_ready_rf", bus.in_ready, 1);
        tick();
        check("sub_A_rf", bus.A, 32'h10);
        check("sub_B",    bus.B, 32'h5);
`endif
        @(negedge clk);
        quiet();
        tick();

        // ---- forwarding priority ----
        @(negedge clk);
        offer(3'b000, 5'd5, 5'd6, 5'd11, 32'h1234_5678, 32'h66);
        bus.mem_wr_en = 1'b1; bus.mem_rd = 5'd5; bus.mem_result = 32'hAAAA_0000;
        bus.wb_wr_en  = 1'b1; bus.wb_rd  = 5'd5; bus.wb_result  = 32'h5555_0000;
`ifdef ID_EX_BYPASS_EN
        tick();
        check("pri_mem_A", bus.A, 32'hAAAA_0000);
        check("pri_B_rf",  bus.B, 32'h66);
        @(negedge clk);
        offer(3'b000, 5'd0, 5'd5, 5'd12, 32'hDEAD, 32'h1);
        bus.mem_rd = 5'd9;
        tick();
        check("r0_A",     bus.A, 32'h0);
        check("pri_wb_B", bus.B, 32'h5555_0000);
        @(negedge clk);
        offer(3'b000, 5'd12, 5'd0, 5'd13, 32'h1, 32'h2);
        bus.ex_result = 32'h77;
        bus.mem_rd    = 5'd12;
        tick();
        check("pri_own_A", bus.A, 32'h77);
        check("r0_B",      bus.B, 32'h0);
`else
        #1 check("pri_stall", bus.stall, 1);
        tick();
        check("pri_bubble", bus.out_valid, 0);
        @(negedge clk);
        bus.mem_wr_en = 1'b0;
        bus.wb_wr_en  = 1'b0;
        #1 check("pri_ready", bus.in_ready, 1);
        tick();
        check("pri_A_rf", bus.A, 32'h1234_5678);
        check("pri_B_rf", bus.B, 32'h66);
`endif
        @(negedge clk);
        quiet();
        tick();

        // ---- load-use ----
        @(negedge clk);
        offer(3'b000, 5'd1, 5'd0, 5'd7, 32'h1000, 32'h0);
        bus.in_is_load  = 1'b1;
        bus.in_use_imm  = 1'b1;
        bus.in_imm_sign = 1'b1;
        bus.in_imm      = 16'h0004;
        tick();
        check("lw_is_load", bus.out_is_load, 1);
        check("lw_A",       bus.A, 32'h1000);
        check("lw_B",       bus.B, 32'h4);
        @(negedge clk);
        offer(3'b000, 5'd7, 5'd2, 5'd8, 32'h0, 32'h3);
        #1 check("lu_stall", bus.stall, 1);
        check("lu_in_ready", bus.in_ready, 0);
        tick();
        check("lu_bubble", bus.out_valid, 0);
        @(negedge clk);
        bus.mem_wr_en = 1'b1; bus.mem_rd = 5'd7; bus.mem_result = 32'hCAFE_0001;
`ifdef ID_EX_BYPASS_EN
        #1 check("lu_stall_off", bus.stall, 0);
        tick();
        check("lu_valid", bus.out_valid, 1);
        check("lu_A_mem", bus.A, 32'hCAFE_0001);
        check("lu_B",     bus.B, 32'h3);
`else
        #1 check("lu_stall_mem", bus.stall, 1);
        tick();
        @(negedge clk);
        bus.mem_wr_en = 1'b0;
        bus.wb_wr_en = 1'b1; bus.wb_rd = 5'd7; bus.wb_result = 32'hCAFE_0001;
        #1 check("lu_stall_wb", bus.stall, 1);
        tick();
        @(negedge clk);
        bus.wb_wr_en = 1'b0;
        bus.in_rs_data = 32'hCAFE_0001;
        #1 check("lu_stall_off", bus.stall, 0);
        tick();
        check("lu_A_rf", bus.A, 32'hCAFE_0001);
        check("lu_B",    bus.B, 32'h3);
`endif
        @(negedge clk);
        quiet();
        tick();

        // ---- back-pressure then flush ----
        @(negedge clk);
        offer(3'b010, 5'd1, 5'd2, 5'd9, 32'h100, 32'h200);
        tick();
        check("bp_valid", bus.out_valid, 1);
        @(negedge clk);
        offer(3'b011, 5'd3, 5'd4, 5'd10, 32'h300, 32'h400);
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_hold_valid", bus.out_valid, 1);
            check("bp_hold_A",     bus.A, 32'h100);
            check("bp_hold_B",     bus.B, 32'h200);
            check("bp_in_ready",   bus.in_ready, 0);
        end
        @(negedge clk);
        bus.flush = 1'b1;
        #1 check("fl_in_ready", bus.in_ready, 0);
        tick();
        check("fl_valid", bus.out_valid, 0);
        @(negedge clk);
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        #1 check("post_fl_ready", bus.in_ready, 1);
        tick();
        check("post_fl_valid", bus.out_valid, 1);
        check("post_fl_A",     bus.A, 32'h300);
        check("post_fl_sel",   bus.ALU_sel, 3'b011);

        // ---- reset mid-transfer ----
        #2 rst = 1'b1;
        #1;
        check("mid_rst_valid",    bus.out_valid, 0);
        check("mid_rst_A",        bus.A, 0);
        check("mid_rst_B",        bus.B, 0);
        check("mid_rst_sel",      bus.ALU_sel, 0);
        check("mid_rst_in_ready", bus.in_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        quiet();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
